// File: rtl/neuron_spike_generator.sv
`default_nettype none
// ============================================================================
// Module      : neuron_spike_generator
// Description : Threshold/refractory stage of a spiking neuron. Accepts a
//               decayed IEEE-754 membrane potential, compares it against a
//               configurable threshold and returns either the unchanged
//               potential or the post-spike reset potential, with a fire flag.
//               Optional macro SPIKE_COUNTER_EN adds a saturating 16-bit
//               count of delivered spikes (output spike_count).
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_spike_generator #(
   parameter int REFR_W = 4
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [31:0]       in_potential,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              cfg_load,
   input  logic [31:0]       cfg_threshold,
   input  logic [31:0]       cfg_reset_potential,
   input  logic [REFR_W-1:0] cfg_refractory,
   output logic [31:0]       out_potential,
   output logic              spike,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef SPIKE_COUNTER_EN
   output logic [15:0]       spike_count,
`endif
   output logic              in_refractory
);

   localparam logic [1:0]  c_IDLE      = 2'd0;
   localparam logic [1:0]  c_EVAL      = 2'd1;
   localparam logic [1:0]  c_OUT       = 2'd2;
   localparam logic [31:0] c_THR_RESET = 32'h41F0_0000; // 30.0

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [31:0]       r_threshold;
   logic [31:0]       r_reset_pot;
   logic [REFR_W-1:0] r_refr_cfg;
   logic [REFR_W-1:0] r_refr_cnt;
   logic [31:0]       r_potential;
   logic [31:0]       r_out_pot;
   logic              r_spike;

   logic w_accept;
   logic w_cfg_we;
   logic w_eval;
   logic w_done;
   logic w_refr_active;
   logic w_nan_pot;
   logic w_nan_thr;
   logic w_fire;

   assign w_accept      = (r_state == c_IDLE) && in_valid;
   assign w_cfg_we      = (r_state == c_IDLE) && cfg_load;
   assign w_eval        = (r_state == c_EVAL);
   assign w_done        = (r_state == c_OUT) && out_ready;
   assign w_refr_active = (r_refr_cnt != '0);

   assign in_ready      = (r_state == c_IDLE);
   assign out_valid     = (r_state == c_OUT);
   assign out_potential = r_out_pot;
   assign spike         = r_spike;
   assign in_refractory = w_refr_active;

   // Next-state logic: IDLE -> EVAL on accept, EVAL -> OUT always, OUT -> IDLE on handshake
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (in_valid)  w_state_nxt = c_EVAL;
         c_EVAL:                 w_state_nxt = c_OUT;
         c_OUT:   if (out_ready) w_state_nxt = c_IDLE;
         default:                w_state_nxt = c_IDLE;
      endcase
   end

   // State register; async reset drops any in-flight sample without an output pulse
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= c_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Configuration registers, writable only while idle so a sample in flight
   // always sees one consistent configuration
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_threshold <= c_THR_RESET;
         r_reset_pot <= 32'h0000_0000;
         r_refr_cfg  <= '0;
      end else if (w_cfg_we) begin
         r_threshold <= cfg_threshold;
         r_reset_pot <= cfg_reset_potential;
         r_refr_cfg  <= cfg_refractory;
      end
   end

   // Latch the incoming potential on the accepting edge
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)      r_potential <= 32'h0000_0000;
      else if (w_accept) r_potential <= in_potential;
   end

   assign w_nan_pot = (&r_potential[30:23]) && (|r_potential[22:0]);
   assign w_nan_thr = (&r_threshold[30:23]) && (|r_threshold[22:0]);

   // Ordered IEEE-754 compare potential >= threshold; NaN never fires, +0 == -0
   always_comb begin
      w_fire = 1'b0;
      if (w_nan_pot || w_nan_thr)
         w_fire = 1'b0;
      else if ((r_potential[30:0] == 31'd0) && (r_threshold[30:0] == 31'd0))
         w_fire = 1'b1;
      else if (r_potential[31] != r_threshold[31])
         w_fire = ~r_potential[31];
      else if (!r_potential[31])
         w_fire = (r_potential[30:0] >= r_threshold[30:0]);
      else
         w_fire = (r_potential[30:0] <= r_threshold[30:0]);
   end

   // Output registers, updated once per sample in EVAL and held through OUT
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_spike   <= 1'b0;
         r_out_pot <= 32'h0000_0000;
      end else if (w_eval) begin
         if (w_refr_active) begin
            r_spike   <= 1'b0;
            r_out_pot <= r_reset_pot;
         end else if (w_fire) begin
            r_spike   <= 1'b1;
            r_out_pot <= r_reset_pot;
         end else begin
            r_spike   <= 1'b0;
            r_out_pot <= r_potential;
         end
      end
   end

   // Refractory counter: counts down one per evaluated sample, reloads on a spike
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_refr_cnt <= '0;
      end else if (w_eval) begin
         if (w_refr_active)
            r_refr_cnt <= r_refr_cnt - REFR_W'(1);
         else if (w_fire)
            r_refr_cnt <= r_refr_cfg;
      end
   end

`ifdef SPIKE_COUNTER_EN
   logic [15:0] r_spike_count;

   // Count spikes as they are handed off to the consumer, saturating at 0xFFFF
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         r_spike_count <= 16'h0000;
      else if (w_done && r_spike && (r_spike_count != 16'hFFFF))
         r_spike_count <= r_spike_count + 16'd1;
   end

   assign spike_count = r_spike_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_neuron_spike_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_spike_generator
// Description : Scoreboard bench for neuron_spike_generator. Directed samples
//               push hand-computed {spike, out_potential} into a queue; a
//               monitor pops and compares on every output handshake.
//               Build with SPIKE_COUNTER_EN to also check spike_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_spike_generator;

   localparam int REFR_W = 4;

   logic              CLK = 1'b0;
   logic              RESET_N = 1'b0;
   logic [31:0]       in_potential = 32'h0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              cfg_load = 1'b0;
   logic [31:0]       cfg_threshold = 32'h0;
   logic [31:0]       cfg_reset_potential = 32'h0;
   logic [REFR_W-1:0] cfg_refractory = '0;
   logic [31:0]       out_potential;
   logic              spike;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              in_refractory;
`ifdef SPIKE_COUNTER_EN
   logic [15:0]       spike_count;
`endif

   neuron_spike_generator #(.REFR_W(REFR_W)) dut (
      .CLK                 (CLK),
      .RESET_N             (RESET_N),
      .in_potential        (in_potential),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .cfg_load            (cfg_load),
      .cfg_threshold       (cfg_threshold),
      .cfg_reset_potential (cfg_reset_potential),
      .cfg_refractory      (cfg_refractory),
      .out_potential       (out_potential),
      .spike               (spike),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
`ifdef SPIKE_COUNTER_EN
      .spike_count         (spike_count),
`endif
      .in_refractory       (in_refractory)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        spike;
      logic [31:0] pot;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a transfer happens on the next rising edge when valid && ready
   always @(negedge CLK) begin
      exp_t e;
      if (RESET_N && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got out_valid=1 pot=%h expected no output", out_potential);
         end else begin
            e = q.pop_front();
            chk("spike", 32'(spike), 32'(e.spike));
            chk("out_potential", out_potential, e.pot);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(in_ready && q.size() == 0) && n < 30) begin
         tick();
         n++;
      end
      if (n >= 30) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout_idle: got busy after %0d cycles expected idle", n);
      end
   endtask

   task automatic send(input logic [31:0] p, input logic s, input logic [31:0] ep);
      wait_idle();
      q.push_back({s, ep});
      in_potential = p;
      in_valid     = 1'b1;
      tick();
      in_valid     = 1'b0;
      wait_idle();
   endtask

   task automatic load(input logic [31:0] thr, input logic [31:0] rp, input logic [REFR_W-1:0] refr);
      wait_idle();
      cfg_threshold       = thr;
      cfg_reset_potential = rp;
      cfg_refractory      = refr;
      cfg_load            = 1'b1;
      tick();
      cfg_load            = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick();
      tick();
      RESET_N = 1'b1;
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_spike", 32'(spike), 32'd0);
      chk("rst_out_potential", out_potential, 32'h0);
      chk("rst_in_refractory", 32'(in_refractory), 32'd0);

      // Default threshold 30.0
      send(32'h4200_0000, 1'b1, 32'h0000_0000);  // 32.0 fires
      send(32'h41F0_0000, 1'b1, 32'h0000_0000);  // 30.0 equality fires
      send(32'h41E8_0000, 1'b0, 32'h41E8_0000);  // 29.0 passes through
      send(32'hC200_0000, 1'b0, 32'hC200_0000);  // -32.0
      send(32'h7FC0_0000, 1'b0, 32'h7FC0_0000);  // NaN never fires

      // Signed-zero and negative-threshold ordering
      load(32'h0000_0000, 32'h3F80_0000, '0);
      send(32'h8000_0000, 1'b1, 32'h3F80_0000);  // -0 >= +0
      send(32'hBF80_0000, 1'b0, 32'hBF80_0000);  // -1 < +0
      load(32'hC000_0000, 32'h3F80_0000, '0);    // threshold -2.0
      send(32'hBF80_0000, 1'b1, 32'h3F80_0000);  // -1 >= -2
      send(32'hC040_0000, 1'b0, 32'hC040_0000);  // -3 < -2
      send(32'h3F80_0000, 1'b1, 32'h3F80_0000);  // +1 >= -2

      // Refractory behaviour
      load(32'h41F0_0000, 32'h0000_0000, 4'd2);
      send(32'h4248_0000, 1'b1, 32'h0);
      chk("refr_after_s1", 32'(in_refractory), 32'd1);
      send(32'h4248_0000, 1'b0, 32'h0);
      chk("refr_after_s2", 32'(in_refractory), 32'd1);
      send(32'h4248_0000, 1'b0, 32'h0);
      chk("refr_after_s3", 32'(in_refractory), 32'd0);
      send(32'h4248_0000, 1'b1, 32'h0);
      chk("refr_after_s4", 32'(in_refractory), 32'd1);
      load(32'h41F0_0000, 32'h0000_0000, 4'd0);
      chk("refr_kept_on_load", 32'(in_refractory), 32'd1);
      send(32'h4248_0000, 1'b0, 32'h0);
      send(32'h4248_0000, 1'b0, 32'h0);
      chk("refr_drained", 32'(in_refractory), 32'd0);

      // Config load together with a sample applies to that sample
      wait_idle();
      cfg_threshold       = 32'h42C8_0000;       // 100.0
      cfg_reset_potential = 32'h0;
      cfg_refractory      = '0;
      cfg_load            = 1'b1;
      in_potential        = 32'h4248_0000;       // 50.0
      in_valid            = 1'b1;
      q.push_back({1'b0, 32'h4248_0000});
      tick();
      cfg_load = 1'b0;
      in_valid = 1'b0;
      wait_idle();
      load(32'h41F0_0000, 32'h0000_0000, 4'd0);

      // Back-pressure stall, with a config load attempted while in OUT
      wait_idle();
      out_ready    = 1'b0;
      q.push_back({1'b1, 32'h0});
      in_potential = 32'h4248_0000;
      in_valid     = 1'b1;
      tick();
      in_valid     = 1'b0;
      chk("eval_in_ready", 32'(in_ready), 32'd0);
      tick();
      cfg_threshold = 32'h42C8_0000;
      cfg_load      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_spike", 32'(spike), 32'd1);
         chk("stall_out_potential", out_potential, 32'h0);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         tick();
         cfg_load = 1'b0;
      end
      out_ready = 1'b1;
      tick();
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      send(32'h4248_0000, 1'b1, 32'h0);          // threshold still 30.0

      // Reset during EVAL
      load(32'h41F0_0000, 32'h3F80_0000, 4'd3);
      send(32'h4248_0000, 1'b1, 32'h3F80_0000);
      wait_idle();
      in_potential = 32'h4248_0000;
      in_valid     = 1'b1;
      tick();
      in_valid     = 1'b0;
      chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_spike", 32'(spike), 32'd0);
      chk("mid_rst_out_potential", out_potential, 32'h0);
      chk("mid_rst_in_refractory", 32'(in_refractory), 32'd0);
      tick();
      RESET_N = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);

      // Config back at reset defaults: threshold 30, reset pot 0, no refractory
      send(32'h4200_0000, 1'b1, 32'h0);
      send(32'h4200_0000, 1'b1, 32'h0);
`ifdef SPIKE_COUNTER_EN
      send(32'h4200_0000, 1'b1, 32'h0);
      chk("spike_count", 32'(spike_count), 32'd3);
`endif

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
